// File: rtl/pll_drp_ctrl.sv
// PLLE4_ADV run-time reconfiguration sequencer: four DRP read-modify-writes of the
// CLKFBOUT/CLKOUT0 divider registers under PLL reset, then lock qualification and system reset release.
module pll_drp_ctrl #(
    parameter int         DRP_TIMEOUT  = 256,
    parameter int         LOCK_TIMEOUT = 65535,
    parameter int         LOCK_STABLE  = 64,
    parameter logic [6:0] ADDR_FB1     = 7'h14,
    parameter logic [6:0] ADDR_FB2     = 7'h15,
    parameter logic [6:0] ADDR_O01     = 7'h08,
    parameter logic [6:0] ADDR_O02     = 7'h09
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [5:0]  cfg_mult_i,
    input  logic [6:0]  cfg_div0_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [6:0]  drp_daddr_o,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    output logic        pll_rst_o,
    input  logic        pll_locked_i,
    output logic        rst_sys_no
);

    localparam int TW_L = $clog2(LOCK_TIMEOUT + 2);
    localparam int TW_D = $clog2(DRP_TIMEOUT + 2);
    localparam int TW   = (TW_L > TW_D) ? TW_L : TW_D;
    localparam int CW   = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {
        IDLE, PRST, RD, RD_W, WR, WR_W, RELEASE, WAIT_LOCK
    } state_t;

    state_t          state, state_nx;
    logic [1:0]      op, op_nx;
    logic [5:0]      mult_q;
    logic [6:0]      div_q;
    logic [TW-1:0]   timer;
    logic            lock_meta, lock_s;
    logic [CW-1:0]   lock_cnt;

    logic            accept, legal, set_err, fin;
    logic            drp_to, lock_to, lock_ok;
    logic [6:0]      n_sel;
    logic [5:0]      n_hi, n_lo;
    logic [15:0]     new_val, mask;

    function automatic logic in_cfg(input state_t s);
        return (s == PRST) || (s == RD) || (s == RD_W) || (s == WR) ||
               (s == WR_W) || (s == RELEASE);
    endfunction

    function automatic logic [6:0] addr_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return ADDR_FB1;
            2'd1:    return ADDR_FB2;
            2'd2:    return ADDR_O01;
            default: return ADDR_O02;
        endcase
    endfunction

    assign accept  = cfg_valid_i & cfg_ready_o;
    assign legal   = (cfg_mult_i != 6'd0) && (cfg_mult_i <= 6'd19) && (cfg_div0_i != 7'd0);
    assign drp_to  = timer >= TW'(DRP_TIMEOUT);
    assign lock_to = timer >= TW'(LOCK_TIMEOUT);
    assign lock_ok = lock_cnt == CW'(LOCK_STABLE);

    // Field values for the register addressed by the current op: odd ops are ClkReg2.
    always_comb begin
        n_sel   = op[1] ? div_q : {1'b0, mult_q};
        n_hi    = n_sel[6:1];
        n_lo    = n_sel[5:0] - n_hi;
        mask    = op[0] ? 16'h00C0 : 16'h0FFF;
        new_val = op[0] ? {8'h00, n_sel[0], (n_sel == 7'd1), 6'h00}
                        : {4'h0, n_hi, n_lo};
    end

    always_comb begin
        state_nx = state;
        op_nx    = op;
        set_err  = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (legal) state_nx = PRST;
                else begin
                    set_err = 1'b1;
                    fin     = 1'b1;
                end
            end
            PRST: begin
                op_nx    = 2'd0;
                state_nx = RD;
            end
            RD:   state_nx = RD_W;
            RD_W: if (drp_drdy_i) state_nx = WR;
                  else if (drp_to) begin
                      set_err  = 1'b1;
                      state_nx = RELEASE;
                  end
            WR:   state_nx = WR_W;
            WR_W: if (drp_drdy_i) begin
                      if (op == 2'd3) state_nx = RELEASE;
                      else begin
                          op_nx    = op + 2'd1;
                          state_nx = RD;
                      end
                  end else if (drp_to) begin
                      set_err  = 1'b1;
                      state_nx = RELEASE;
                  end
            RELEASE: state_nx = WAIT_LOCK;
            WAIT_LOCK: if (lock_ok) begin
                           fin      = 1'b1;
                           state_nx = IDLE;
                       end else if (lock_to) begin
                           set_err  = 1'b1;
                           fin      = 1'b1;
                           state_nx = IDLE;
                       end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            op          <= 2'd0;
            mult_q      <= 6'd0;
            div_q       <= 7'd0;
            timer       <= '0;
            cfg_ready_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            drp_daddr_o <= 7'd0;
            drp_den_o   <= 1'b0;
            drp_dwe_o   <= 1'b0;
            drp_di_o    <= 16'd0;
            pll_rst_o   <= 1'b0;
        end else begin
            state       <= state_nx;
            op          <= op_nx;
            cfg_ready_o <= (state_nx == IDLE);
            busy_o      <= (state_nx != IDLE);
            done_o      <= fin;
            drp_den_o   <= (state_nx == RD) || (state_nx == WR);
            drp_dwe_o   <= (state_nx == WR);
            pll_rst_o   <= in_cfg(state_nx) && (state_nx != RELEASE);

            // One timer serves both the DRP and the lock timeouts; it restarts on every state change.
            if (state_nx != state)  timer <= '0;
            else if (timer != '1)   timer <= timer + TW'(1);

            if (set_err)               err_o <= 1'b1;
            else if (accept && legal)  err_o <= 1'b0;

            if (accept && legal) begin
                mult_q <= cfg_mult_i;
                div_q  <= cfg_div0_i;
            end
            if (state_nx == RD)
                drp_daddr_o <= addr_of(op_nx);
            if (state == RD_W && drp_drdy_i)
                drp_di_o <= (drp_do_i & ~mask) | (new_val & mask);
        end
    end

    // Lock qualification; rst_sys_no gates on the synced lock directly so a drop is seen in 3 cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            lock_cnt   <= '0;
            rst_sys_no <= 1'b0;
        end else begin
            lock_meta  <= pll_locked_i;
            lock_s     <= lock_meta;
            if (in_cfg(state) || !lock_s) lock_cnt <= '0;
            else if (!lock_ok)            lock_cnt <= lock_cnt + CW'(1);
            rst_sys_no <= lock_ok && lock_s && !in_cfg(state_nx);
        end
    end

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Bench for pll_drp_ctrl: DRP register-file mock with random latency, simple PLL lock mock,
// table and random requests checked against an arithmetic model of the divider register fields.
module tb_pll_drp_ctrl;

    localparam int LS = 64;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [5:0]  cfg_mult;
    logic [6:0]  cfg_div0;
    logic        busy, done, err;
    logic [6:0]  daddr;
    logic        den, dwe;
    logic [15:0] di, rdo;
    logic        drdy;
    logic        pll_rst, pll_locked, rst_sys_n;

    // bench-controlled knobs
    logic auto_mode = 1'b0, man_lock = 1'b0, drop_lock = 1'b0;
    logic drop_fb2 = 1'b0, slow = 1'b0, mem_seed = 1'b0;

    // mocks
    logic        auto_lock = 1'b0;
    int          relock_cnt = 0;
    logic [15:0] mem [128];
    logic        pend = 1'b0, pw = 1'b0;
    logic [6:0]  pa = 7'd0;
    logic [15:0] pd = 16'd0;
    int          lat = 0;

    int den_cnt = 0, wr_cnt = 0, done_cnt = 0, proto_err = 0;
    logic prev_den = 1'b0;

    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    pll_drp_ctrl dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_mult_i(cfg_mult), .cfg_div0_i(cfg_div0),
        .busy_o(busy), .done_o(done), .err_o(err),
        .drp_daddr_o(daddr), .drp_den_o(den), .drp_dwe_o(dwe),
        .drp_di_o(di), .drp_do_i(rdo), .drp_drdy_i(drdy),
        .pll_rst_o(pll_rst), .pll_locked_i(pll_locked), .rst_sys_no(rst_sys_n)
    );

    assign pll_locked = auto_mode ? (auto_lock & ~drop_lock) : man_lock;

    // PLL: loses lock in reset, relocks 20 cycles after release
    always @(posedge clk) begin
        if (pll_rst) begin
            auto_lock  <= 1'b0;
            relock_cnt <= 0;
        end else if (relock_cnt < 20) relock_cnt <= relock_cnt + 1;
        else auto_lock <= 1'b1;
    end

    // DRP port: answers each DEN after 0..4 extra cycles (10 when slow); can swallow the FB2 write
    always @(posedge clk) begin
        drdy <= 1'b0;
        if (mem_seed)
            for (int i = 0; i < 128; i++) mem[i] <= 16'($urandom);
        if (pend) begin
            if (lat == 0) begin
                drdy <= 1'b1;
                pend <= 1'b0;
                if (pw) mem[pa] <= pd;
                else    rdo <= mem[pa];
            end else lat <= lat - 1;
        end
        if (den) begin
            pend <= !(dwe && daddr == 7'h15 && drop_fb2);
            pa   <= daddr;
            pw   <= dwe;
            pd   <= di;
            lat  <= slow ? 10 : int'($urandom_range(0, 4));
        end
    end

    always @(posedge clk) begin
        if (den)         den_cnt   <= den_cnt + 1;
        if (den && dwe)  wr_cnt    <= wr_cnt + 1;
        if (done)        done_cnt  <= done_cnt + 1;
        if ((dwe && !den) || (den && prev_den)) proto_err <= proto_err + 1;
        prev_den <= den;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: register contents from the divide value using plain arithmetic
    function automatic logic [15:0] field(input int n, input bit reg2);
        int hi, lo;
        hi = n / 2;
        lo = n - hi;
        if (reg2) return 16'((n % 2) * 128 + ((n == 1) ? 64 : 0));
        return 16'((hi % 64) * 64 + (lo % 64));
    endfunction

    function automatic bit is_legal(input int m, input int d);
        return (m >= 1) && (m <= 19) && (d >= 1);
    endfunction

    task automatic run_vec(input string tag, input int m, input int d, input bit drop,
                           input bit exp_err, input int exp_den);
        logic [6:0]  a [4];
        logic [15:0] pre [4];
        logic [15:0] msk, expv;
        int den0, wr0, done0, n, writes_ok;
        a = '{7'h14, 7'h15, 7'h08, 7'h09};
        for (int i = 0; i < 4; i++) pre[i] = mem[a[i]];
        den0 = den_cnt; wr0 = wr_cnt; done0 = done_cnt;
        drop_fb2 = drop;
        n = 0;
        while (!cfg_ready && n < 2000) begin @(negedge clk); n++; end
        chk({tag, " ready"}, cfg_ready, 1'b1);
        cfg_valid = 1'b1; cfg_mult = 6'(m); cfg_div0 = 7'(d);
        @(negedge clk);
        cfg_valid = 1'b0;
        n = 0;
        while (!done && n < 6000) begin @(negedge clk); n++; end
        chk({tag, " done seen"}, done, 1'b1);
        if (exp_den == 0) chk({tag, " done latency"}, n, 0);
        chk({tag, " err"}, err, exp_err);
        repeat (3) @(negedge clk);
        chk({tag, " den count"}, den_cnt - den0, exp_den);
        chk({tag, " write count"}, wr_cnt - wr0, exp_den / 2);
        chk({tag, " done count"}, done_cnt - done0, 1);
        chk({tag, " pll_rst"}, pll_rst, 1'b0);
        chk({tag, " busy"}, busy, 1'b0);
        if (exp_den > 0) chk({tag, " rst_sys_n"}, rst_sys_n, 1'b1);
        writes_ok = drop ? 1 : exp_den / 2;
        for (int i = 0; i < 4; i++) begin
            msk  = (i % 2) ? 16'h00C0 : 16'h0FFF;
            expv = pre[i];
            if (i < writes_ok) expv = (pre[i] & ~msk) | (field((i < 2) ? m : d, i % 2) & msk);
            chk($sformatf("%s reg %0h", tag, a[i]), mem[a[i]], expv);
        end
        drop_fb2 = 1'b0;
    endtask

    typedef struct {
        int mult; int div0; bit drop; bit exp_err; int exp_den;
    } vec_t;

    initial begin
        vec_t tbl [7];
        int   n, m, d;
        bit   found;
        tbl[0] = '{10, 60,  1'b0, 1'b0, 8};
        tbl[1] = '{19, 1,   1'b0, 1'b0, 8};
        tbl[2] = '{1,  127, 1'b0, 1'b0, 8};
        tbl[3] = '{0,  5,   1'b0, 1'b1, 0};
        tbl[4] = '{20, 5,   1'b0, 1'b1, 0};
        tbl[5] = '{5,  0,   1'b0, 1'b1, 0};
        tbl[6] = '{10, 60,  1'b1, 1'b1, 4};

        rst_ni = 1'b0; cfg_valid = 1'b0; cfg_mult = 6'd0; cfg_div0 = 7'd0;
        mem_seed = 1'b1;
        repeat (3) @(negedge clk);
        mem_seed = 1'b0;
        chk("reset ready", cfg_ready, 1'b0);
        chk("reset busy/done/err", {busy, done, err}, 3'b000);
        chk("reset den/dwe", {den, dwe}, 2'b00);
        chk("reset daddr/di", {daddr, di}, 23'd0);
        chk("reset pll_rst/rst_sys_n", {pll_rst, rst_sys_n}, 2'b00);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("ready after reset", cfg_ready, 1'b1);

        // power-up: lock after 10 cycles, system reset released LS+3 cycles later
        repeat (9) @(negedge clk);
        man_lock = 1'b1;
        for (int k = 1; k <= LS + 3; k++) begin
            @(negedge clk);
            if (k == LS + 2) chk("powerup rst_sys_n early", rst_sys_n, 1'b0);
            if (k == LS + 3) chk("powerup rst_sys_n", rst_sys_n, 1'b1);
        end
        chk("powerup den count", den_cnt, 0);
        auto_mode = 1'b1;

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("tbl%0d", i), tbl[i].mult, tbl[i].div0, tbl[i].drop,
                    tbl[i].exp_err, tbl[i].exp_den);

        for (int r = 0; r < 6; r++) begin
            m = $urandom_range(0, 21);
            d = $urandom_range(0, 127);
            run_vec($sformatf("rnd%0d m%0d d%0d", r, m, d), m, d, 1'b0,
                    !is_legal(m, d), is_legal(m, d) ? 8 : 0);
        end

        // lock loss in IDLE
        chk("lockdrop pre", rst_sys_n, 1'b1);
        drop_lock = 1'b1;
        repeat (3) @(negedge clk);
        chk("lockdrop rst_sys_n", rst_sys_n, 1'b0);
        drop_lock = 1'b0;
        repeat (LS + 10) @(negedge clk);

        // async reset while waiting for a DRP read
        slow = 1'b1;
        cfg_valid = 1'b1; cfg_mult = 6'd10; cfg_div0 = 7'd60;
        @(negedge clk);
        cfg_valid = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 50) begin
            @(negedge clk); n++;
            if (den && !dwe) found = 1'b1;
        end
        chk("rst test read seen", found, 1'b1);
        @(negedge clk);
        chk("rst test pll_rst before", pll_rst, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst test den/dwe", {den, dwe}, 2'b00);
        chk("rst test pll_rst", pll_rst, 1'b0);
        chk("rst test busy", busy, 1'b0);
        @(negedge clk);
        rst_ni = 1'b1;
        slow = 1'b0;
        @(negedge clk);
        chk("rst test ready", cfg_ready, 1'b1);
        repeat (20) @(negedge clk);
        run_vec("post-reset", 7, 9, 1'b0, 1'b0, 8);

        chk("drp strobe protocol", proto_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
